// File: rtl/sha512_arbiter_pkg.sv
// Shared definitions for the SHA-512 requester arbiter: tag layout,
// result widths, FSM encoding and the in-flight counter update rule.
package sha512_arbiter_pkg;

    localparam int NREQ_MAX = 8;
    localparam int IDX_W    = 8;
    localparam int TAG_W    = 24;
    localparam int OID_W    = IDX_W + TAG_W;
    localparam int LEN_W    = 61;
    localparam int SHA_W    = 512;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Two-bit saturating up/down counter step; simultaneous inc and dec cancel.
    function automatic logic [1:0] inflight_next(input logic [1:0] cur,
                                                 input logic       inc,
                                                 input logic       dec);
        logic [1:0] nxt;
        nxt = cur;
        if (inc && !dec) begin
            if (cur != 2'd3) nxt = cur + 2'd1;
        end else if (dec && !inc) begin
            if (cur != 2'd0) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sha512_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first asserted request
// at or after the pointer, wrapping modulo NREQ.
module sha512_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int GW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [GW-1:0]   ptr_i,
    output logic [GW-1:0]   idx_o,
    output logic            found_o
);

    logic [GW:0] cand;

    // Scan NREQ candidates starting at the pointer; first hit wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_i} + (GW+1)'(k);
            if (cand >= (GW+1)'(NREQ)) cand = cand - (GW+1)'(NREQ);
            if (!found_o && req_i[cand[GW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/sha512_arbiter.sv
// Arbitrates byte streams from NREQ requesters onto one SHA-512 core input,
// locking the grant for a whole message, and routes core results back to
// the originating requester by the index carried in the upper tag byte.
module sha512_arbiter
    import sha512_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         cfg_en,
    input  logic [NREQ-1:0]         s_tvalid,
    output logic [NREQ-1:0]         s_tready,
    input  logic [NREQ-1:0]         s_tlast,
    input  logic [NREQ*TAG_W-1:0]   s_tid,
    input  logic [NREQ*8-1:0]       s_tdata,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    input  logic                    m_tready,
    output logic [OID_W-1:0]        m_tid,
    output logic [7:0]              m_tdata,
    input  logic                    c_ovalid,
    input  logic [OID_W-1:0]        c_oid,
    input  logic [LEN_W-1:0]        c_olen,
    input  logic [SHA_W-1:0]        c_osha,
    output logic [NREQ-1:0]         r_valid,
    output logic [TAG_W-1:0]        r_id,
    output logic [LEN_W-1:0]        r_len,
    output logic [SHA_W-1:0]        r_sha,
    output logic                    busy,
    output logic                    err_oid
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [GW-1:0]     gnt_q, gnt_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [1:0]        inflight_q, inflight_d;
    logic [NREQ-1:0]   r_valid_q, r_valid_d;
    logic              err_q, err_d;
    logic [TAG_W-1:0]  r_id_q, r_id_d;
    logic [LEN_W-1:0]  r_len_q, r_len_d;
    logic [SHA_W-1:0]  r_sha_q, r_sha_d;

    logic [GW-1:0]     pick_idx;
    logic              pick_found;
    logic              sel_valid, sel_last;
    logic [7:0]        sel_data;
    logic [TAG_W-1:0]  sel_tid;
    logic              accept_last;

    sha512_arbiter_rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_rr_pick (
        .req_i   (s_tvalid & cfg_en),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Select the granted requester's stream signals.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_tid   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q == GW'(i)) begin
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
                sel_data  = s_tdata[i*8 +: 8];
                sel_tid   = s_tid[i*TAG_W +: TAG_W];
            end
        end
    end

    // Next-state and stream-path outputs; the grant is only released by an
    // accepted last byte, so cfg_en changes never cut a message short.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        m_tdata     = '0;
        m_tid       = '0;
        s_tready    = '0;
        accept_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                m_tvalid = sel_valid;
                m_tlast  = sel_last;
                m_tdata  = sel_data;
                m_tid    = {{(IDX_W-GW){1'b0}}, gnt_q, sel_tid};
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt_q == GW'(i)) s_tready[i] = m_tready;
                end
                if (sel_valid && m_tready && sel_last) begin
                    accept_last = 1'b1;
                    state_d     = ST_IDLE;
                    rr_ptr_d    = (gnt_q == GW'(NREQ-1)) ? '0 : gnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Route a core result to its requester, or flag an out-of-range index.
    always_comb begin
        r_valid_d = '0;
        err_d     = 1'b0;
        r_id_d    = r_id_q;
        r_len_d   = r_len_q;
        r_sha_d   = r_sha_q;
        if (c_ovalid) begin
            r_id_d  = c_oid[TAG_W-1:0];
            r_len_d = c_olen;
            r_sha_d = c_osha;
            if (c_oid[OID_W-1:TAG_W] < IDX_W'(NREQ)) begin
                r_valid_d[c_oid[TAG_W +: GW]] = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign inflight_d = inflight_next(inflight_q, accept_last, c_ovalid);

    // Arbitration state: FSM, locked grant and round-robin pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Count messages handed to the core whose result has not come back.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    // Result bus registers: strobes last one cycle, payload holds.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid_q <= '0;
            err_q     <= 1'b0;
            r_id_q    <= '0;
            r_len_q   <= '0;
            r_sha_q   <= '0;
        end else begin
            r_valid_q <= r_valid_d;
            err_q     <= err_d;
            r_id_q    <= r_id_d;
            r_len_q   <= r_len_d;
            r_sha_q   <= r_sha_d;
        end
    end

    assign r_valid = r_valid_q;
    assign err_oid = err_q;
    assign r_id    = r_id_q;
    assign r_len   = r_len_q;
    assign r_sha   = r_sha_q;
    assign busy    = (state_q == ST_GRANT) || (inflight_q != 2'd0);

endmodule

// File: tb/tb_sha512_arbiter.sv
// Directed bench for sha512_arbiter at NREQ=4; the SHA core is stood in for
// by directly driven c_* result inputs.
module tb_sha512_arbiter;

    localparam int NREQ = 4;
    localparam logic [511:0] SHA_ABC =
        512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;

    logic          clk = 1'b0;
    logic          rstn;
    logic [3:0]    cfg_en, s_tvalid, s_tready, s_tlast;
    logic [95:0]   s_tid;
    logic [31:0]   s_tdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic [31:0]   m_tid;
    logic [7:0]    m_tdata;
    logic          c_ovalid;
    logic [31:0]   c_oid;
    logic [60:0]   c_olen;
    logic [511:0]  c_osha;
    logic [3:0]    r_valid;
    logic [23:0]   r_id;
    logic [60:0]   r_len;
    logic [511:0]  r_sha;
    logic          busy, err_oid;

    int vectors = 0;
    int errors  = 0;
    logic [7:0] msg [$];

    always #5 clk = ~clk;

    sha512_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rstn(rstn), .cfg_en(cfg_en),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tid(s_tid), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .m_tid(m_tid), .m_tdata(m_tdata),
        .c_ovalid(c_ovalid), .c_oid(c_oid), .c_olen(c_olen), .c_osha(c_osha),
        .r_valid(r_valid), .r_id(r_id), .r_len(r_len), .r_sha(r_sha),
        .busy(busy), .err_oid(err_oid)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rstn = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Stream msg[] from requester idx; hook_kind 1 clears cfg_en[idx] and
    // hook_kind 2 asserts reset when byte hook_at is being presented.
    task automatic stream(input int idx, input logic [23:0] tag, input int hook_at,
                          input int hook_kind, input bit stall, output int sent);
        int  k;
        bit  xfer;
        bit  done;
        k = 0; sent = 0; done = 0;
        s_tid[idx*24 +: 24] = tag;
        s_tdata[idx*8 +: 8] = msg[0];
        s_tlast[idx]  = (msg.size() == 1);
        s_tvalid[idx] = 1'b1;
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            m_tready = stall ? (cyc % 3 != 2) : 1'b1;
            @(negedge clk);
            if (k == hook_at && hook_kind == 1) cfg_en[idx] = 1'b0;
            if (k == hook_at && hook_kind == 2) begin
                rstn = 1'b0;
                #1;
                vectors++;
                if ({busy, m_tvalid, s_tready, r_valid, err_oid} !== 11'd0 ||
                    r_id !== 24'd0 || r_len !== 61'd0 || r_sha !== 512'd0) begin
                    errors++;
                    $display("FAIL mid_reset_outputs: busy=%b m_tvalid=%b s_tready=%b r_valid=%b err=%b r_id=%h r_len=%0d, required all zero",
                             busy, m_tvalid, s_tready, r_valid, err_oid, r_id, r_len);
                end
                s_tvalid = '0;
                s_tlast  = '0;
                @(posedge clk);
                @(posedge clk);
                #1 rstn = 1'b1;
                done = 1;
            end else begin
                xfer = s_tready[idx] && s_tvalid[idx];
                if (xfer) begin
                    vectors++;
                    if (m_tvalid !== 1'b1 || m_tdata !== msg[k] ||
                        m_tid !== {8'(idx), tag} ||
                        m_tlast !== 1'(k == msg.size() - 1) ||
                        s_tready !== (4'd1 << idx)) begin
                        errors++;
                        $display("FAIL stream_byte %0d req %0d: data=%h tid=%h last=%b rdy=%b, required data=%h tid=%h last=%b rdy=%b",
                                 k, idx, m_tdata, m_tid, m_tlast, s_tready, msg[k],
                                 {8'(idx), tag}, (k == msg.size() - 1), (4'd1 << idx));
                    end
                end
                @(posedge clk);
                #1;
                if (xfer) begin
                    k++;
                    sent = k;
                    if (k == msg.size()) begin
                        s_tvalid[idx] = 1'b0;
                        s_tlast[idx]  = 1'b0;
                        done = 1;
                    end else begin
                        s_tdata[idx*8 +: 8] = msg[k];
                        s_tlast[idx] = (k == msg.size() - 1);
                    end
                end
            end
        end
        m_tready = 1'b1;
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL stream_timeout req %0d: %0d bytes sent, required %0d", idx, k, msg.size());
        end
    endtask

    // Present one core result and check the routed strobe / error pulse.
    task automatic core_result(input logic [31:0] oid, input logic [60:0] len,
                               input logic [511:0] sha, input logic [3:0] exp_rv,
                               input logic exp_err, input bit check_bus);
        c_ovalid = 1'b1; c_oid = oid; c_olen = len; c_osha = sha;
        @(posedge clk);
        #1 c_ovalid = 1'b0;
        vectors++;
        if (r_valid !== exp_rv || err_oid !== exp_err) begin
            errors++;
            $display("FAIL result_strobe oid=%h: r_valid=%b err=%b, required r_valid=%b err=%b",
                     oid, r_valid, err_oid, exp_rv, exp_err);
        end
        if (check_bus) begin
            vectors++;
            if (r_id !== oid[23:0] || r_len !== len || r_sha !== sha) begin
                errors++;
                $display("FAIL result_bus: r_id=%h r_len=%0d r_sha_hi=%h, required r_id=%h r_len=%0d r_sha_hi=%h",
                         r_id, r_len, r_sha[511:448], oid[23:0], len, sha[511:448]);
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (r_valid !== 4'd0 || err_oid !== 1'b0) begin
            errors++;
            $display("FAIL result_one_cycle: r_valid=%b err=%b, required 0000 0", r_valid, err_oid);
        end
        if (check_bus) begin
            vectors++;
            if (r_id !== oid[23:0] || r_len !== len) begin
                errors++;
                $display("FAIL result_hold: r_id=%h r_len=%0d, required %h %0d", r_id, r_len, oid[23:0], len);
            end
        end
    endtask

    task automatic check_busy(input string name, input logic exp);
        vectors++;
        if (busy !== exp) begin
            errors++;
            $display("FAIL %s: busy=%b, required %b", name, busy, exp);
        end
    endtask

    // All requesters hold single-byte messages; expect alternate IDLE/GRANT.
    task automatic check_rotation(input string name, input int seq[5]);
        int e;
        for (int i = 0; i < 4; i++) begin
            s_tid[i*24 +: 24] = 24'h100 + 24'(i);
            s_tdata[i*8 +: 8] = 8'hA0 + 8'(i);
        end
        s_tlast  = 4'hF;
        s_tvalid = 4'hF;
        m_tready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            vectors++;
            if (n % 2 == 0) begin
                if (m_tvalid !== 1'b0 || s_tready !== 4'd0) begin
                    errors++;
                    $display("FAIL %s idle slot %0d: m_tvalid=%b s_tready=%b, required 0 0000",
                             name, n, m_tvalid, s_tready);
                end
            end else begin
                e = seq[n/2];
                if (m_tvalid !== 1'b1 || m_tid !== {8'(e), 24'h100 + 24'(e)} ||
                    m_tdata !== 8'hA0 + 8'(e) || s_tready !== (4'd1 << e)) begin
                    errors++;
                    $display("FAIL %s grant slot %0d: m_tvalid=%b tid=%h data=%h rdy=%b, required grant to %0d",
                             name, n, m_tvalid, m_tid, m_tdata, s_tready, e);
                end
            end
        end
        @(posedge clk);
        #1 s_tvalid = '0;
        s_tlast = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        s_tvalid = 4'hF; s_tlast = 4'hF;
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== 4'd0 || r_valid !== 4'd0 || err_oid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b m_tvalid=%b s_tready=%b r_valid=%b err=%b, required all 0",
                     busy, m_tvalid, s_tready, r_valid, err_oid);
        end
        vectors++;
        if (r_id !== 24'd0 || r_len !== 61'd0 || r_sha !== 512'd0) begin
            errors++;
            $display("FAIL reset_bus: r_id=%h r_len=%0d, required 0", r_id, r_len);
        end
        s_tvalid = '0; s_tlast = '0;
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_abc();
        int sent;
        msg = '{8'h61, 8'h62, 8'h63};
        stream(0, 24'h000011, -1, 0, 1'b0, sent);
        vectors++;
        if (sent !== 3) begin
            errors++;
            $display("FAIL abc_count: sent=%0d, required 3", sent);
        end
        check_busy("abc_busy_inflight", 1'b1);
        core_result(32'h00000011, 61'd3, SHA_ABC, 4'b0001, 1'b0, 1'b1);
        vectors++;
        if (r_sha[511:448] !== 64'hddaf35a193617aba) begin
            errors++;
            $display("FAIL abc_sha_prefix: %h, required ddaf35a193617aba", r_sha[511:448]);
        end
        check_busy("abc_busy_done", 1'b0);
    endtask

    task automatic test_round_robin();
        do_reset();
        cfg_en = 4'hF;
        check_rotation("round_robin", '{0, 1, 2, 3, 0});
        check_busy("rr_inflight_sat", 1'b1);
        core_result(32'h00000100, 61'd1, 512'h1, 4'b0001, 1'b0, 1'b1);
        core_result(32'h01000101, 61'd1, 512'h2, 4'b0010, 1'b0, 1'b1);
        check_busy("rr_after_two_results", 1'b1);
        core_result(32'h03000103, 61'd1, 512'h3, 4'b1000, 1'b0, 1'b1);
        check_busy("rr_after_three_results", 1'b0);
    endtask

    task automatic test_cfg_mask();
        do_reset();
        cfg_en = 4'b1011;
        check_rotation("cfg_mask", '{0, 1, 3, 0, 1});
        cfg_en = 4'hF;
    endtask

    task automatic test_bad_oid();
        do_reset();
        core_result(32'h07000000, 61'd0, 512'd0, 4'b0000, 1'b1, 1'b0);
        check_busy("bad_oid_inflight", 1'b0);
    endtask

    task automatic test_cfg_clear();
        int sent;
        do_reset();
        cfg_en = 4'hF;
        msg = {};
        for (int k = 0; k < 200; k++) msg.push_back(8'((k * 3 + 5) & 8'hFF));
        stream(1, 24'h00BEEF, 100, 1, 1'b1, sent);
        vectors++;
        if (sent !== 200) begin
            errors++;
            $display("FAIL cfg_clear_count: sent=%0d, required 200", sent);
        end
        cfg_en = 4'hF;
        core_result(32'h0100BEEF, 61'd200, 512'hABCD, 4'b0010, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int sent;
        msg = {};
        for (int k = 0; k < 100; k++) msg.push_back(8'(k + 16));
        stream(2, 24'h000222, 50, 2, 1'b0, sent);
        vectors++;
        if (sent !== 50) begin
            errors++;
            $display("FAIL reset_mid_count: sent=%0d, required 50", sent);
        end
        s_tid[1*24 +: 24] = 24'h000111;
        s_tid[3*24 +: 24] = 24'h000333;
        s_tlast  = 4'b1010;
        s_tvalid = 4'b1010;
        @(negedge clk);
        vectors++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle: m_tvalid=%b busy=%b, required 0 0", m_tvalid, busy);
        end
        @(negedge clk);
        vectors++;
        if (m_tvalid !== 1'b1 || m_tid !== 32'h01000111) begin
            errors++;
            $display("FAIL reset_mid_first_grant: m_tvalid=%b m_tid=%h, required 1 01000111", m_tvalid, m_tid);
        end
        @(posedge clk);
        #1 s_tvalid = '0;
        s_tlast = '0;
    endtask

    initial begin
        rstn = 1'b0;
        cfg_en = 4'hF; s_tvalid = '0; s_tlast = '0; s_tid = '0; s_tdata = '0;
        m_tready = 1'b1;
        c_ovalid = 1'b0; c_oid = '0; c_olen = '0; c_osha = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_abc();
        test_round_robin();
        test_cfg_mask();
        test_bad_oid();
        test_cfg_clear();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sha512_arbiter.md
SHA512_ARBITER -- requirements
Module: sha512_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requester ports (2..8).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 cfg_en  input  NREQ  per-requester enable mask; 0 = never granted.
REQ-005 s_tvalid  input  NREQ  per-requester byte valid.
REQ-006 s_tready  output  NREQ  per-requester byte ready.
REQ-007 s_tlast  input  NREQ  per-requester last byte of message.
REQ-008 s_tid  input  NREQ*24  per-requester message tag (requester i at bits [24i+23:24i]).
REQ-009 s_tdata  input  NREQ*8  per-requester byte data.
REQ-010 m_tvalid, m_tlast  output  1 each  to core input.
REQ-011 m_tready  input  1  from core input.
REQ-012 m_tid  output  32  to core; m_tid = {8-bit granted index, 24-bit requester tag}.
REQ-013 m_tdata  output  8  to core.
REQ-014 c_ovalid  input  1; c_oid  input  32; c_olen  input  61; c_osha  input  512; core result.
REQ-015 r_valid  output  NREQ  one-hot result strobe, one cycle.
REQ-016 r_id  output  24; r_len  output  61; r_sha  output  512; shared result bus, qualified by r_valid.
REQ-017 busy  output  1  grant held or any message in flight.
REQ-018 err_oid  output  1  one-cycle pulse on an unroutable result.

Function
REQ-019 The FSM SHALL have states IDLE and GRANT.
REQ-020 In IDLE, m_tvalid and all s_tready SHALL be 0.
REQ-021 In IDLE, the block SHALL select the first index at or after rr_ptr, wrapping modulo NREQ, with s_tvalid=1 and cfg_en=1; it SHALL register that index as gnt and go to GRANT the next cycle.
REQ-022 In IDLE with no eligible requester, the block SHALL stay in IDLE.
REQ-023 In GRANT, m_tvalid/m_tlast/m_tdata SHALL combinationally equal s_*[gnt], and s_tready[gnt] SHALL equal m_tready; all other s_tready SHALL be 0.
REQ-024 A byte SHALL transfer only when the valid and ready of the same port are both 1.
REQ-025 The grant SHALL stay locked until a transfer with s_tlast[gnt]=1; the next cycle the FSM SHALL be in IDLE with rr_ptr = (gnt+1) mod NREQ.
REQ-026 Clearing cfg_en[gnt] in mid-message SHALL NOT revoke the grant; it takes effect at the next arbitration only.
REQ-027 Between messages there SHALL be exactly one IDLE cycle (no back-to-back grants).
REQ-028 The 2-bit inflight counter SHALL increment on an accepted tlast and decrement on c_ovalid; when both occur in one cycle it SHALL be unchanged; it saturates at 3 and does not decrement below 0.
REQ-029 busy SHALL be (state==GRANT) | (inflight!=0).
REQ-030 On c_ovalid with c_oid[31:24] < NREQ, the cycle after SHALL assert r_valid[c_oid[31:24]] for one cycle with r_id=c_oid[23:0], r_len=c_olen, r_sha=c_osha.
REQ-031 On c_ovalid with c_oid[31:24] >= NREQ, r_valid SHALL stay 0 and err_oid SHALL pulse the cycle after.
REQ-032 r_id/r_len/r_sha SHALL hold their value until the next c_ovalid.

Reset
REQ-033 While rstn=0: state=IDLE, gnt=0, rr_ptr=0, inflight=0, r_valid=0, r_id=0, r_len=0, r_sha=0, err_oid=0, busy=0, m_tvalid=0, s_tready=0.
REQ-034 Reset in mid-message SHALL abandon the message; the first arbitration after release SHALL start from index 0.

Structure
REQ-035 The shared package SHALL hold NREQ_MAX=8, the tag widths (index 8, tag 24), and the FSM state encoding (IDLE=0, GRANT=1).
REQ-036 The round-robin selector (request vector and pointer in, index and found out) SHALL be one combinational sub-module, rr_pick; the core SHALL be instantiated by the parent, not inside this block.

Verification
REQ-037 Requester 0 sends "abc" with tag 0x000011 -> r_valid[0] pulses, r_id=0x000011, r_len=3, r_sha begins 0xddaf35a193617aba.
REQ-038 All 4 requesters hold tvalid from reset -> grants go 0,1,2,3,0, each with one IDLE cycle between messages.
REQ-039 cfg_en=4'b1011 with all requesters valid -> requester 2 is never granted.
REQ-040 cfg_en[gnt] cleared mid-message (200-byte message) -> all 200 bytes reach the core and the result returns to that requester.
REQ-041 A forced c_ovalid with c_oid=0x07000000 at NREQ=4 -> err_oid pulses once, r_valid stays 0, inflight is unchanged when no other event occurs.
REQ-042 rstn pulsed while byte 50 of 100 is streaming -> all outputs return to reset values, and the next grant goes to the lowest enabled valid index.
